// File: rtl/huffman_pkg.sv
// Shared Huffman code table and FSM state type, used by both ends of the serial link.
package huffman_pkg;
   localparam int MAX_LEN = 10;
   localparam int ASCII_W = 7;
   localparam int LEN_W   = 4;

   typedef struct packed {
      logic [MAX_LEN-1:0] code;
      logic [LEN_W-1:0]   len;
   } tbl_entry_t;

   typedef enum logic [1:0] {ACCUM, CHECK, HOLD} dec_state_t;

   // ' '=00, 'e'=010, a-z=10+idx5, A-Z=110+idx5, 0-9=1110+idx4; other chars have len 0.
   // Prefixes 011 and 1111 are never assigned, so such streams can only end in an error.
   function automatic tbl_entry_t code_table(input logic [ASCII_W-1:0] ch);
      tbl_entry_t ent;
      ent = '0;
      if (ch == 7'h20) begin
         ent.code = 10'b00_0000_0000;
         ent.len  = 4'd2;
      end else if (ch == 7'h65) begin
         ent.code = 10'b00_0000_0010;
         ent.len  = 4'd3;
      end else if (ch >= 7'h61 && ch <= 7'h7A) begin
         ent.code = {3'b000, 2'b10, 5'(ch - 7'h61)};
         ent.len  = 4'd7;
      end else if (ch >= 7'h41 && ch <= 7'h5A) begin
         ent.code = {2'b00, 3'b110, 5'(ch - 7'h41)};
         ent.len  = 4'd8;
      end else if (ch >= 7'h30 && ch <= 7'h39) begin
         ent.code = {2'b00, 4'b1110, 4'(ch - 7'h30)};
         ent.len  = 4'd8;
      end
      return ent;
   endfunction
endpackage

// File: rtl/huffman_match.sv
// Combinational reverse lookup: finds the symbol whose code equals the low cnt bits of acc.
module huffman_match
   import huffman_pkg::*;
(
   input  logic [MAX_LEN-1:0] acc,
   input  logic [LEN_W-1:0]   cnt,
   output logic               hit,
   output logic [ASCII_W-1:0] ascii
);
   tbl_entry_t         ent;
   logic [MAX_LEN-1:0] mask;

   always_comb begin
      hit   = 1'b0;
      ascii = '0;
      ent   = '0;
      mask  = ~({MAX_LEN{1'b1}} << cnt);
      // Table is prefix-free, so at most one symbol can satisfy the length+code test.
      for (int s = 0; s < (1 << ASCII_W); s++) begin
         ent = code_table(ASCII_W'(s));
         if (ent.len != '0 && ent.len == cnt && (ent.code & mask) == (acc & mask)) begin
            hit   = 1'b1;
            ascii = ASCII_W'(s);
         end
      end
   end
endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial MSB-first Huffman decoder: one bit per two cycles in, one ASCII char out on ready/valid.
module huffman_decoder #(
   parameter int MAX_LEN   = 10,
   parameter int ERR_CNT_W = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          bit_in,
   input  logic                          bit_valid,
   output logic                          bit_ready,
   input  logic                          flush,
   output logic [huffman_pkg::ASCII_W-1:0] ascii_out,
   output logic                          char_valid,
   input  logic                          char_ready,
   output logic                          code_err,
   output logic [ERR_CNT_W-1:0]          err_count,
   output logic                          busy
);
   import huffman_pkg::*;

   dec_state_t         state, state_nxt;
   logic [MAX_LEN-1:0] acc, acc_nxt;
   logic [LEN_W-1:0]   cnt, cnt_nxt;
   logic [ASCII_W-1:0] ascii_nxt, match_ascii;
   logic               valid_nxt, err_nxt, match_hit;
   logic [ERR_CNT_W-1:0] err_count_nxt;

   huffman_match u_match (
      .acc   (acc),
      .cnt   (cnt),
      .hit   (match_hit),
      .ascii (match_ascii)
   );

   assign bit_ready = (state == ACCUM) && !flush && !reset;
   assign busy      = (cnt != '0) || char_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ACCUM;
         acc        <= '0;
         cnt        <= '0;
         ascii_out  <= '0;
         char_valid <= 1'b0;
         code_err   <= 1'b0;
         err_count  <= '0;
      end else begin
         state      <= state_nxt;
         acc        <= acc_nxt;
         cnt        <= cnt_nxt;
         ascii_out  <= ascii_nxt;
         char_valid <= valid_nxt;
         code_err   <= err_nxt;
         err_count  <= err_count_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc;
      cnt_nxt       = cnt;
      ascii_nxt     = ascii_out;
      valid_nxt     = char_valid;
      err_nxt       = 1'b0;
      err_count_nxt = err_count;
      if (flush) begin
         // Drops partial code and any pending character; the error tally survives.
         state_nxt = ACCUM;
         acc_nxt   = '0;
         cnt_nxt   = '0;
         valid_nxt = 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (bit_valid && bit_ready) begin
                  acc_nxt   = {acc[MAX_LEN-2:0], bit_in};
                  cnt_nxt   = cnt + LEN_W'(1);
                  state_nxt = CHECK;
               end
            end
            CHECK: begin
               if (match_hit) begin
                  ascii_nxt = match_ascii;
                  valid_nxt = 1'b1;
                  acc_nxt   = '0;
                  cnt_nxt   = '0;
                  state_nxt = HOLD;
               end else if (cnt == LEN_W'(MAX_LEN)) begin
                  err_nxt = 1'b1;
                  if (err_count != '1) err_count_nxt = err_count + ERR_CNT_W'(1);
                  acc_nxt   = '0;
                  cnt_nxt   = '0;
                  state_nxt = ACCUM;
               end else begin
                  state_nxt = ACCUM;
               end
            end
            HOLD: begin
               if (char_ready) begin
                  valid_nxt = 1'b0;
                  state_nxt = ACCUM;
               end
            end
            default: state_nxt = ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench: stimulus pushes expected chars/errors, a negedge monitor pops and compares.
module tb_huffman_decoder;
   logic       clk, reset, bit_in, bit_valid, bit_ready, flush;
   logic       char_valid, char_ready, code_err, busy;
   logic [6:0] ascii_out;
   logic [7:0] err_count;

   typedef struct {
      bit         is_err;
      logic [6:0] ch;
   } exp_t;

   exp_t  sb[$];
   int    n_chk = 0, n_fail = 0, cyc = 0, last_hs_cyc = 0, mon_err = 0, lat = 0;
   bit    rand_rdy = 0;
   string cs = "the QUICK brown fox 0123456789 JUMPS over a lazy DOG";
   string hello = "HELLO";

   huffman_decoder #(.MAX_LEN(10), .ERR_CNT_W(8)) dut (
      .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .flush(flush), .ascii_out(ascii_out),
      .char_valid(char_valid), .char_ready(char_ready), .code_err(code_err),
      .err_count(err_count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rand_rdy) begin #1 char_ready = ($urandom_range(3, 0) != 0); end

   // Code assignment written out from the table definition as bit strings.
   function automatic string enc(input byte c);
      if (c == 8'h20) return "00";
      if (c == 8'h65) return "010";
      if (c >= 8'h61 && c <= 8'h7A) return $sformatf("10%05b", c - 8'h61);
      if (c >= 8'h41 && c <= 8'h5A) return $sformatf("110%05b", c - 8'h41);
      if (c >= 8'h30 && c <= 8'h39) return $sformatf("1110%04b", c - 8'h30);
      return "";
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_event(input bit is_err, input int ch);
      exp_t e;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_event: got %s 0x%0h, expected none", is_err ? "code_err" : "char", ch);
         return;
      end
      e = sb.pop_front();
      chk("event_kind_is_err", int'(is_err), int'(e.is_err));
      if (!is_err && !e.is_err) chk("char_value", ch, int'(e.ch));
   endtask

   always @(negedge clk) begin
      if (reset) mon_err = 0;
      else begin
         if (code_err) begin
            mon_err++;
            check_event(1'b1, 0);
            chk("err_count_sat", int'(err_count), (mon_err > 255) ? 255 : mon_err);
         end
         if (char_valid && char_ready && !flush) check_event(1'b0, int'(ascii_out));
      end
   end

   // Entered and left #1 after a rising edge; each bit held until accepted.
   task automatic send_code(input string bits, input int max_gap);
      for (int i = 0; i < bits.len(); i++) begin
         int w;
         repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
         bit_valid = 1'b1;
         bit_in    = (bits[i] == "1");
         w = 0;
         @(negedge clk);
         while (!bit_ready && w < 50) begin @(negedge clk); w++; end
         if (!bit_ready) begin
            chk("bit_ready_timeout", int'(bit_ready), 1);
            bit_valid = 1'b0;
            return;
         end
         last_hs_cyc = cyc;
         @(posedge clk); #1;
         bit_valid = 1'b0;
      end
   endtask

   task automatic send_char(input byte c, input bit push, input int max_gap);
      if (push) sb.push_back('{is_err: 1'b0, ch: c[6:0]});
      send_code(enc(c), max_gap);
   endtask

   task automatic send_bad(input string bits);
      sb.push_back('{is_err: 1'b1, ch: 7'h0});
      send_code(bits, 0);
   endtask

   task automatic wait_valid(output int l);
      int w = 0;
      @(negedge clk);
      while (!char_valid && w < 100) begin @(negedge clk); w++; end
      chk("char_valid_rise", int'(char_valid), 1);
      l = cyc - last_hs_cyc;
   endtask

   task automatic wait_drain();
      int w = 0;
      while (sb.size() != 0 && w < 3000) begin @(posedge clk); w++; end
      chk("scoreboard_drained", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; char_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_char_valid", int'(char_valid), 0);
      chk("rst_ascii_out", int'(ascii_out), 0);
      chk("rst_err_count", int'(err_count), 0);
      chk("rst_code_err", int'(code_err), 0);
      chk("rst_busy", int'(busy), 0);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("bit_ready_after_reset", int'(bit_ready), 1);
      @(posedge clk); #1;

      // Single 'e' with the sink always ready.
      send_char(8'h65, 1'b1, 0);
      wait_valid(lat);
      chk("latency_e", lat, 2);
      chk("ascii_e", int'(ascii_out), 'h65);
      @(negedge clk);
      chk("valid_one_cycle", int'(char_valid), 0);
      chk("bit_ready_after_char", int'(bit_ready), 1);
      chk("ascii_retained", int'(ascii_out), 'h65);
      @(posedge clk); #1;

      // Backpressure on 'A'.
      char_ready = 1'b0;
      send_char(8'h41, 1'b1, 0);
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", int'(char_valid), 1);
         chk("bp_ascii", int'(ascii_out), 'h41);
         chk("bp_bit_ready", int'(bit_ready), 0);
      end
      @(posedge clk); #1;
      char_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release", int'(char_valid), 0);
      @(posedge clk); #1;

      // HELLO with random gaps between bits.
      for (int i = 0; i < hello.len(); i++) send_char(hello[i], 1'b1, 3);
      wait_drain();

      // Ten bits that never form a code.
      send_bad("0110000000");
      @(negedge clk);
      chk("err_not_early", int'(code_err), 0);
      @(negedge clk);
      chk("err_pulse", int'(code_err), 1);
      chk("err_count_one", int'(err_count), 1);
      chk("busy_after_err", int'(busy), 0);
      @(negedge clk);
      chk("err_pulse_end", int'(code_err), 0);
      @(posedge clk); #1;
      send_char(8'h65, 1'b1, 0);
      wait_valid(lat);
      chk("ascii_after_err", int'(ascii_out), 'h65);
      @(posedge clk); #1;

      // Flush of a partial uppercase prefix, with a bit offered during the flush.
      send_code("110", 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_partial", int'(busy), 1);
      @(posedge clk); #1;
      flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
      @(negedge clk);
      chk("bit_ready_in_flush", int'(bit_ready), 0);
      @(posedge clk); #1;
      flush = 1'b0; bit_valid = 1'b0;
      @(negedge clk);
      chk("busy_after_flush", int'(busy), 0);
      @(posedge clk); #1;
      send_char(8'h41, 1'b1, 0);
      wait_valid(lat);
      chk("ascii_after_flush", int'(ascii_out), 'h41);
      @(posedge clk); #1;

      // Flush together with char_ready in HOLD drops the character.
      char_ready = 1'b0;
      send_char(8'h41, 1'b0, 0);
      wait_valid(lat);
      @(posedge clk); #1;
      flush = 1'b1; char_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_hold_valid", int'(char_valid), 0);
      chk("flush_hold_busy", int'(busy), 0);
      @(posedge clk); #1;

      // Asynchronous reset while holding 'e'.
      char_ready = 1'b0;
      send_char(8'h65, 1'b0, 0);
      wait_valid(lat);
      chk("hold_ascii_e", int'(ascii_out), 'h65);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", int'(char_valid), 0);
      chk("arst_ascii", int'(ascii_out), 0);
      chk("arst_err_count", int'(err_count), 0);
      chk("arst_busy", int'(busy), 0);
      @(negedge clk);
      #2 reset = 1'b0;
      char_ready = 1'b1;
      @(posedge clk); #1;

      // Random mix of characters and bad codes under random sink backpressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(7, 0) == 0) send_bad($sformatf("1111%06b", $urandom_range(63, 0)));
         else send_char(cs[$urandom_range(cs.len() - 1, 0)], 1'b1, 2);
      end
      wait_drain();
      rand_rdy = 1'b0;
      @(posedge clk); #2 char_ready = 1'b1;
      @(posedge clk); #1;

      // Error counter saturation.
      for (int i = 0; i < 300; i++) send_bad("1111111111");
      wait_drain();
      chk("err_count_saturated", int'(err_count), 'hFF);
      chk("queue_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
